// File: rtl/data_mem.sv
// rtl/data_mem.sv - byte-addressable little-endian data memory with fault detection
//
// Purpose: DEPTH_WORDS x 32-bit data memory for a load/store unit. Supports
// byte, halfword and word accesses with sign/zero extension on loads, lane
// merging on stores, and flags out-of-range or misaligned accesses. The first
// faulting address since reset is latched in a sticky error register.
//
// Ports:
//   clk        - clock, all state updates on rising edge
//   rst        - asynchronous active-high reset (clears memory and error state)
//   addr       - byte address
//   wdata      - store data (low-order bits for byte/half stores)
//   mem_read   - load request
//   mem_write  - store request
//   size       - 00 byte, 01 half, 10 word, 11 illegal
//   sign_ext   - sign-extend byte/half loads when 1
//   rdata      - combinational load data
//   fault      - combinational fault for the current access
//   err_flag   - sticky fault indicator
//   err_addr   - address of the first faulting access since reset

module data_mem #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] rdata,
    output logic        fault,
    output logic        err_flag,
    output logic [31:0] err_addr
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem_words [DEPTH_WORDS];
    logic [AW-1:0] word_idx;
    logic [31:0]   word_rd;
    logic          active;
    logic          out_of_range;
    logic          misaligned;
    logic          we;

    logic [3:0]    lane_mask;
    logic [31:0]   bit_mask;
    logic [31:0]   wdata_rep;
    logic [31:0]   word_d;

    logic [7:0]    byte_v;
    logic [15:0]   half_v;

    logic          err_flag_q;
    logic [31:0]   err_addr_q;

    assign word_idx     = addr[AW+1:2];
    assign word_rd      = mem_words[word_idx];
    assign active       = mem_read | mem_write;
    assign out_of_range = |addr[31:AW+2];

    always_comb begin
        misaligned = 1'b1;
        case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = |addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    assign fault = active & (out_of_range | misaligned);
    assign we    = mem_write & ~fault;

    // Load path: reads the pre-write contents, so a same-cycle read/write
    // returns old data and the new word is visible after the edge.
    always_comb begin
        byte_v = word_rd[{addr[1:0], 3'b000} +: 8];
        half_v = addr[1] ? word_rd[31:16] : word_rd[15:0];
        rdata  = '0;
        if (mem_read && !fault) begin
            case (size)
                2'b00:   rdata = {{24{sign_ext & byte_v[7]}}, byte_v};
                2'b01:   rdata = {{16{sign_ext & half_v[15]}}, half_v};
                2'b10:   rdata = word_rd;
                default: rdata = '0;
            endcase
        end
    end

    // Store path: replicate the store data across lanes and merge only the
    // addressed lanes into the current word.
    always_comb begin
        lane_mask = 4'b0000;
        wdata_rep = wdata;
        case (size)
            2'b00: begin
                lane_mask = 4'b0001 << addr[1:0];
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                lane_mask = addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            2'b10: begin
                lane_mask = 4'b1111;
                wdata_rep = wdata;
            end
            default: begin
                lane_mask = 4'b0000;
                wdata_rep = wdata;
            end
        endcase
        bit_mask = '0;
        for (int i = 0; i < 4; i++) begin
            bit_mask[8*i +: 8] = {8{lane_mask[i]}};
        end
        word_d = (word_rd & ~bit_mask) | (wdata_rep & bit_mask);
    end

    // One register per word so every word can be cleared asynchronously.
    for (genvar w = 0; w < DEPTH_WORDS; w++) begin : g_word
        logic [31:0] word_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                word_q <= '0;
            end else if (we && (word_idx == AW'(w))) begin
                word_q <= word_d;
            end
        end

        assign mem_words[w] = word_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_flag_q <= 1'b0;
            err_addr_q <= '0;
        end else if (fault && !err_flag_q) begin
            err_flag_q <= 1'b1;
            err_addr_q <= addr;
        end
    end

    assign err_flag = err_flag_q;
    assign err_addr = err_addr_q;

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words stored (power of two, 4..1024).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port addr  input  32  byte address, driven by the ALU result.
REQ-005 SHALL have port wdata  input  32  store data; the value is held in its low-order bits for byte/half stores.
REQ-006 SHALL have port mem_read  input  1  load request.
REQ-007 SHALL have port mem_write  input  1  store request.
REQ-008 SHALL have port size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 SHALL have port sign_ext  input  1  for byte/half loads: 1 sign-extend, 0 zero-extend.
REQ-010 SHALL have port rdata  output  32  load data (combinational).
REQ-011 SHALL have port fault  output  1  current access is faulting (combinational).
REQ-012 SHALL have port err_flag  output  1  sticky fault indicator (registered).
REQ-013 SHALL have port err_addr  output  32  address of the first faulting access since reset (registered).

Function
REQ-014 SHALL store DEPTH_WORDS words in little-endian byte order; word index = addr[log2(DEPTH_WORDS)+1:2]; byte lane = addr[1:0].
REQ-015 SHALL define the access as active when mem_read or mem_write is 1; an idle cycle SHALL have no fault and no state change.
REQ-016 SHALL flag out_of_range when any addr bit at or above log2(DEPTH_WORDS)+2 is 1.
REQ-017 SHALL flag misaligned when size=01 and addr[0]=1, or size=10 and addr[1:0]!=00; size=11 SHALL always be misaligned.
REQ-018 SHALL drive fault = active AND (out_of_range OR misaligned), combinationally in the same cycle.
REQ-019 SHALL drive rdata = 0 whenever mem_read=0 or fault=1.
REQ-020 SHALL drive rdata combinationally from the current contents for a non-faulting read: word read = the full word; half read = lane [15:0] or [31:16] selected by addr[1]; byte read = the lane selected by addr[1:0]; the upper bits are extended per sign_ext.
REQ-021 SHALL write at the rising clk edge only when mem_write=1 and fault=0, updating only the addressed lanes (byte: 8 bits from wdata[7:0]; half: 16 bits from wdata[15:0]; word: all 32 bits); other lanes SHALL be preserved.
REQ-022 SHALL, with mem_read and mem_write both 1 to the same address, present the pre-write contents on rdata during that cycle, with the new contents visible from the next cycle.
REQ-023 SHALL, on the rising edge of a faulting cycle with err_flag=0, set err_flag=1 and capture err_addr=addr.
REQ-024 SHALL, once err_flag=1, leave err_flag and err_addr unchanged by any later fault; only rst clears them.
REQ-025 SHALL suppress any write on a faulting cycle, with no partial-lane writes.

Reset
REQ-026 SHALL, while rst=1, asynchronously clear every memory word to 0x00000000, err_flag to 0 and err_addr to 0x00000000.
REQ-027 SHALL drop any store pending in the same cycle that rst rises; after rst falls, the first write SHALL take effect on the first rising clk edge with rst=0.
REQ-028 SHALL give rdata=0 and fault=0 after reset when the inputs are idle; a read of any valid address SHALL return 0 until that address is written.

Verification
REQ-029 SHALL cover word store/load: write 0xDEADBEEF to addr 0x10 with size=10 -> next cycle read of 0x10 with size=10 returns 0xDEADBEEF.
REQ-030 SHALL cover lane merge and extension: after REQ-029, store byte 0x7F to 0x13 -> word read returns 0x7FADBEEF; byte read of 0x12 with sign_ext=1 returns 0xFFFFFFAD; with sign_ext=0 returns 0x000000AD; half read of 0x10 with sign_ext=1 returns 0xFFFFBEEF.
REQ-031 SHALL cover a misaligned store: word store to 0x22 -> fault=1 that cycle, word 0x20 unchanged, err_flag=1 and err_addr=0x00000022 after the edge; a later out-of-range read at 0x1000 -> fault=1, rdata=0, err_addr still 0x00000022.
REQ-032 SHALL cover simultaneous read/write: mem_read=mem_write=1 at 0x40 holding 0x11111111, wdata=0x22222222 -> rdata=0x11111111 before the edge and 0x22222222 after it.
REQ-033 SHALL cover reset mid-operation: assert rst between clock edges while a store is pending -> rdata=0, err_flag=0 immediately; after release, a read of 0x10 returns 0x00000000.
REQ-034 SHALL cover the address boundaries (DEPTH_WORDS=256): word store to 0x3FC succeeds and reads back; store to 0x400 faults, with no write and no wrap-around into word 0.
